// File: rtl/clock_divider_counter.sv
// Programmable clock divider: counts enabled cycles up to a loadable limit,
// emitting a one-cycle tick and toggling a divided clock on every wrap.
module clock_divider_counter #(
  parameter int unsigned      WIDTH         = 32,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = WIDTH'(32'd24999999)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] half_period,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] limit,
  output logic             tick,
  output logic             clk_out
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             terminal_c;

  // Wrap when the count reaches the limit; using >= means an all-ones limit
  // wraps at all-ones and the increment can never overflow.
  assign terminal_c = (count_q >= limit_q);

  // Next-state: load overrides counting, disabled cycles hold everything.
  always_comb begin
    count_d   = count_q;
    limit_d   = limit_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (load) begin
      limit_d   = half_period;
      count_d   = '0;
      clk_out_d = 1'b0;
    end else if (enable) begin
      if (terminal_c) begin
        count_d   = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      limit_q   <= DEFAULT_LIMIT;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      limit_q   <= limit_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign count   = count_q;
  assign limit   = limit_q;
  assign tick    = tick_q;
  assign clk_out = clk_out_q;

endmodule

// File: tb/tb_clock_divider_counter.sv
// Directed bench for clock_divider_counter: a 32-bit instance with limit 3
// after reset, plus a 4-bit instance exercising the all-ones limit wrap.
module tb_clock_divider_counter;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        load;
  logic [31:0] half_period;
  logic [31:0] count;
  logic [31:0] limit;
  logic        tick;
  logic        clk_out;

  logic        en4;
  logic        ld4;
  logic [3:0]  hp4;
  logic [3:0]  count4;
  logic [3:0]  limit4;
  logic        tick4;
  logic        clk_out4;

  int checks;
  int errors;

  clock_divider_counter #(.WIDTH(32), .DEFAULT_LIMIT(32'd3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .half_period(half_period), .count(count), .limit(limit),
    .tick(tick), .clk_out(clk_out)
  );

  clock_divider_counter #(.WIDTH(4), .DEFAULT_LIMIT(4'hF)) dut4 (
    .clock(clock), .reset(reset), .enable(en4), .load(ld4),
    .half_period(hp4), .count(count4), .limit(limit4),
    .tick(tick4), .clk_out(clk_out4)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [31:0] value);
    load = 1'b1;
    half_period = value;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (limit !== 32'd3) begin errors++; $display("FAIL reset_limit: got %0d want 3", limit); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b want 0", tick); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out: got %0b want 0", clk_out); end
    checks++; if (limit4 !== 4'hF) begin errors++; $display("FAIL reset_limit4: got %0d want 15", limit4); end
    reset = 1'b0;
  endtask

  // Limit 3: count 1,2,3,0 ..., tick on every 4th edge, clk_out period 8.
  task automatic test_default_run();
    logic [31:0] exp_count;
    logic        exp_tick;
    logic        exp_clk;
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_count = 32'(k % 4);
      exp_tick  = (k % 4 == 0);
      exp_clk   = ((k / 4) % 2) == 1;
      checks++; if (count !== exp_count) begin errors++; $display("FAIL run_count[%0d]: got %0d want %0d", k, count, exp_count); end
      checks++; if (tick !== exp_tick) begin errors++; $display("FAIL run_tick[%0d]: got %0b want %0b", k, tick, exp_tick); end
      checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL run_clk_out[%0d]: got %0b want %0b", k, clk_out, exp_clk); end
    end
  endtask

  // Two more enabled edges give count 2, then three disabled edges hold it.
  task automatic test_hold();
    step();
    step();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (count !== 32'd2) begin errors++; $display("FAIL hold_count[%0d]: got %0d want 2", k, count); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL hold_tick[%0d]: got %0b want 0", k, tick); end
    end
  endtask

  // Alternating enable with limit 3: tick lands on clock 7 (4th enabled edge).
  task automatic test_toggle_enable();
    logic [31:0] exp_count [8] = '{32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd0, 32'd0};
    logic        exp_tick  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_load(32'd3);
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL toggle_load_count: got %0d want 0", count); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL toggle_load_clk_out: got %0b want 0", clk_out); end
    for (int k = 0; k < 8; k++) begin
      enable = (k % 2 == 0);
      step();
      checks++; if (count !== exp_count[k]) begin errors++; $display("FAIL toggle_count[%0d]: got %0d want %0d", k, count, exp_count[k]); end
      checks++; if (tick !== exp_tick[k]) begin errors++; $display("FAIL toggle_tick[%0d]: got %0b want %0b", k, tick, exp_tick[k]); end
    end
    enable = 1'b0;
  endtask

  // Reload mid-count (count 2, limit 5) to limit 1, then tick every 2 cycles.
  task automatic test_load_mid();
    logic [31:0] exp_count [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
    logic        exp_tick  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        exp_clk   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_load(32'd5);
    enable = 1'b1;
    step();
    step();
    checks++; if (count !== 32'd2) begin errors++; $display("FAIL mid_pre_count: got %0d want 2", count); end
    do_load(32'd1);
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", count); end
    checks++; if (limit !== 32'd1) begin errors++; $display("FAIL mid_limit: got %0d want 1", limit); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL mid_clk_out: got %0b want 0", clk_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL mid_tick: got %0b want 0", tick); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (count !== exp_count[k]) begin errors++; $display("FAIL mid_run_count[%0d]: got %0d want %0d", k, count, exp_count[k]); end
      checks++; if (tick !== exp_tick[k]) begin errors++; $display("FAIL mid_run_tick[%0d]: got %0b want %0b", k, tick, exp_tick[k]); end
      checks++; if (clk_out !== exp_clk[k]) begin errors++; $display("FAIL mid_run_clk_out[%0d]: got %0b want %0b", k, clk_out, exp_clk[k]); end
    end
  endtask

  // Load in the terminal cycle beats the wrap.
  task automatic test_load_priority();
    do_load(32'd4);
    for (int k = 0; k < 4; k++) step();
    checks++; if (count !== 32'd4) begin errors++; $display("FAIL prio_pre_count: got %0d want 4", count); end
    do_load(32'd7);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL prio_tick: got %0b want 0", tick); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL prio_count: got %0d want 0", count); end
    checks++; if (limit !== 32'd7) begin errors++; $display("FAIL prio_limit: got %0d want 7", limit); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL prio_clk_out: got %0b want 0", clk_out); end
  endtask

  // Limit 0 divides by two: tick every cycle, clk_out toggles every cycle.
  task automatic test_limit_zero();
    logic exp_clk;
    enable = 1'b0;
    do_load(32'd0);
    checks++; if (limit !== 32'd0) begin errors++; $display("FAIL zero_limit: got %0d want 0", limit); end
    enable = 1'b1;
    exp_clk = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_clk = ~exp_clk;
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL zero_tick[%0d]: got %0b want 1", k, tick); end
      checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL zero_clk_out[%0d]: got %0b want %0b", k, clk_out, exp_clk); end
      checks++; if (count !== 32'd0) begin errors++; $display("FAIL zero_count[%0d]: got %0d want 0", k, count); end
    end
  endtask

  // Async reset mid-period with clk_out high; reset dominates load/enable.
  task automatic test_async_reset();
    do_load(32'd2);
    for (int k = 0; k < 5; k++) step();
    checks++; if (count !== 32'd2) begin errors++; $display("FAIL ares_pre_count: got %0d want 2", count); end
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL ares_pre_clk_out: got %0b want 1", clk_out); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL ares_count: got %0d want 0", count); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL ares_clk_out: got %0b want 0", clk_out); end
    checks++; if (limit !== 32'd3) begin errors++; $display("FAIL ares_limit: got %0d want 3", limit); end
    load = 1'b1;
    half_period = 32'd9;
    step();
    checks++; if (limit !== 32'd3) begin errors++; $display("FAIL ares_prio_limit: got %0d want 3", limit); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL ares_prio_count: got %0d want 0", count); end
    load = 1'b0;
    #2;
    reset = 1'b0;
    step();
    checks++; if (count !== 32'd1) begin errors++; $display("FAIL ares_restart_count: got %0d want 1", count); end
    enable = 1'b0;
  endtask

  // 4-bit instance with all-ones limit: count reaches 15 then wraps with tick.
  task automatic test_wide_wrap();
    for (int k = 0; k < 15; k++) step_en4();
    checks++; if (count4 !== 4'hF) begin errors++; $display("FAIL wrap_count15: got %0d want 15", count4); end
    checks++; if (tick4 !== 1'b0) begin errors++; $display("FAIL wrap_tick15: got %0b want 0", tick4); end
    step_en4();
    checks++; if (count4 !== 4'h0) begin errors++; $display("FAIL wrap_count0: got %0d want 0", count4); end
    checks++; if (tick4 !== 1'b1) begin errors++; $display("FAIL wrap_tick: got %0b want 1", tick4); end
    checks++; if (clk_out4 !== 1'b1) begin errors++; $display("FAIL wrap_clk_out: got %0b want 1", clk_out4); end
    en4 = 1'b0;
  endtask

  task automatic step_en4();
    en4 = 1'b1;
    step();
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    enable = 1'b0;
    load = 1'b0;
    half_period = '0;
    en4 = 1'b0;
    ld4 = 1'b0;
    hp4 = '0;
    checks = 0;
    errors = 0;
    test_reset();
    test_default_run();
    test_hold();
    test_toggle_enable();
    test_load_mid();
    test_load_priority();
    test_limit_zero();
    test_async_reset();
    test_wide_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
